tcs34725_reader: RTL and testbench
==================================

# tcs34725_reader

Sequencer that brings up a TCS34725 colour sensor and streams its four 16-bit channel counts (clear, red, green, blue) with a one-cycle `data_valid` strobe to the colour-classification logic downstream. It sits between a transaction-level I2C master and that classifier. It issues register writes and reads through a valid/ready request channel and collects the read bytes from a response channel. It polls the sensor's AVALID status bit, assembles burst-read bytes into channel words, and recovers from NACKs by re-initialising.

## Interface
Parameters:
- `PON_WAIT_CYC`, 120000: idle cycles after power-on write (2.4 ms at 50 MHz).
- `POLL_GAP_CYC`, 5000: idle cycles between status polls and after each sample.
- `ERR_BACKOFF_CYC`, 500000: idle cycles after a NACK before re-init.
- `ATIME_VAL`, 8'hF6: value written to ATIME.
- `GAIN_VAL`, 2'b01: value written to CONTROL[1:0].

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` out 1: request to the I2C master.
- `req_ready` in 1: the master accepts the request.
- `req_write` out 1: 1 = single-byte register write, 0 = read.
- `req_cmd` out 8: command byte (0x80 | addr, or 0xA0 | addr for auto-increment).
- `req_wdata` out 8: write data; 0 for reads.
- `req_len` out 4: read byte count (1–8); 0 for writes.
- `rsp_valid` in 1: one beat per read byte, or one beat for a write.
- `rsp_data` in 8: read byte; ignored for writes.
- `rsp_last` in 1: final beat of the transaction.
- `rsp_err` in 1: NACK; valid only with `rsp_last`.
- `clear`, `red`, `green`, `blue` out 16 each: latest channel counts.
- `data_valid` out 1: one-cycle pulse when the channels update.
- `sensor_ready` out 1: high after init completes, low during init and backoff.
- `nack_err` out 1: one-cycle pulse per NACK'd transaction.

## Operation
- FSM states: PON → PON_WAIT → WR_ATIME → WR_CTRL → WR_EN → POLL → POLL_WAIT → READ → PUBLISH → GAP → POLL. Error path: ERR_BACKOFF → PON.
- Write states issue the following, then wait for the single response beat:
  - PON: cmd 0x80, data 0x01.
  - WR_ATIME: cmd 0x81, data `ATIME_VAL`.
  - WR_CTRL: cmd 0x8F, data {6'b0, `GAIN_VAL`}.
  - WR_EN: cmd 0x80, data 0x03. Its successful response sets `sensor_ready`.
- POLL: read cmd 0x93, len 1.
  - If rsp_data[0] (AVALID) = 1, go to READ.
  - Otherwise go to POLL_WAIT, idle `POLL_GAP_CYC` cycles, then return to POLL.
- READ: read cmd 0xB4, len 8. Beats arrive in order CL, CH, RL, RH, GL, GH, BL, BH. A 3-bit beat index writes each beat into an 8-byte shadow buffer.
- PUBLISH: on a clean final beat, load clear={CH,CL}, red={RH,RL}, green={GH,GL}, blue={BH,BL}. All four load in the same cycle, and `data_valid` = 1 in that cycle.
- GAP: idle `POLL_GAP_CYC` cycles.
- NACK in any state (`rsp_err`=1 with `rsp_last`):
  - pulse `nack_err`; clear `sensor_ready`;
  - discard the shadow buffer; channel outputs hold their prior values; no `data_valid`;
  - idle `ERR_BACKOFF_CYC` cycles, then restart at PON.
- Defensive case: `rsp_last` arriving with beat index ≠ 7 in READ is treated as a NACK.
- Only one request is outstanding at a time. The next request is not raised until `rsp_last` of the previous one.
- Wait counter: 24 bits, loaded with the parameter value minus 1 on entry, counts down to 0. All parameters must be ≥ 1 and < 2^24.

## Timing
- Reset values: `req_valid`=0, `req_write`=0, `req_cmd`=0, `req_wdata`=0, `req_len`=0, all channel outputs 0, `data_valid`=0, `sensor_ready`=0, `nack_err`=0. FSM = PON.
- First `req_valid` rises in the first cycle after reset deasserts.
- Request handshake:
  - transfer occurs when `req_valid` & `req_ready` are high on the same edge;
  - `req_*` payload holds stable while `req_valid`=1 and `req_ready`=0;
  - `req_valid` drops the cycle after transfer.
- Responses are never back-pressured. Beats may arrive in the cycle directly after the transfer.
- `data_valid` and the channel update occur 1 cycle after the READ `rsp_last` edge.
- A wait state lasting N cycles holds exactly N cycles; the next request rises in cycle N+1.
- Reset asserted mid-transaction: all outputs return to reset values immediately. Any in-flight response beats after reset release are ignored until the FSM's own request is accepted.
- `nack_err` pulses in the cycle after the erroring `rsp_last`.

## Test plan
- Init sequence: `req_ready` always 1, write responses clean → requests in order (0x80/0x01), PON_WAIT of exactly `PON_WAIT_CYC` cycles, (0x81/0xF6), (0x8F/0x01), (0x80/0x03); `sensor_ready`=1 after the last response.
- Back-pressure: hold `req_ready`=0 for 7 cycles on the ATIME write → `req_cmd`=0x81 and `req_wdata`=0xF6 stable throughout; exactly one transfer.
- Poll then read: status 0x00 twice, then 0x11 → two POLL_GAP waits, then read 0xB4 len 8. Beats 34 12 78 56 BC 9A F0 DE → clear=0x1234, red=0x5678, green=0x9ABC, blue=0xDEF0, with a single `data_valid` pulse 1 cycle after the last beat.
- NACK mid-read: err on beat 8 → `nack_err` pulse; channels keep their previous values; no `data_valid`; `sensor_ready`=0; after `ERR_BACKOFF_CYC` cycles `req_cmd`=0x80 / `req_wdata`=0x01.
- Short read: `rsp_last` on beat 5 → handled as NACK, same response as above.
- Reset mid-read (after 3 beats): all outputs return to 0; after release, first request is 0x80/0x01.

Source files
------------

// File: rtl/tcs34725_reader.sv
// TCS34725 bring-up and polling sequencer driving a transaction-level I2C
// master; streams clear/red/green/blue counts with a one-cycle strobe.
module tcs34725_reader #(
    parameter int unsigned PON_WAIT_CYC    = 120000,
    parameter int unsigned POLL_GAP_CYC    = 5000,
    parameter int unsigned ERR_BACKOFF_CYC = 500000,
    parameter logic [7:0]  ATIME_VAL       = 8'hF6,
    parameter logic [1:0]  GAIN_VAL        = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [7:0]  req_cmd,
    output logic [7:0]  req_wdata,
    output logic [3:0]  req_len,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_last,
    input  logic        rsp_err,
    output logic [15:0] clear,
    output logic [15:0] red,
    output logic [15:0] green,
    output logic [15:0] blue,
    output logic        data_valid,
    output logic        sensor_ready,
    output logic        nack_err
);

    localparam logic [23:0] PON_LD = 24'(PON_WAIT_CYC - 1);
    localparam logic [23:0] GAP_LD = 24'(POLL_GAP_CYC - 1);
    localparam logic [23:0] ERR_LD = 24'(ERR_BACKOFF_CYC - 1);

    typedef enum logic [3:0] {
        S_PON,
        S_PON_WAIT,
        S_WR_ATIME,
        S_WR_CTRL,
        S_WR_EN,
        S_POLL,
        S_POLL_WAIT,
        S_READ,
        S_PUBLISH,
        S_GAP,
        S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [23:0] cnt_q, cnt_d;

    logic        req_valid_q;
    logic        busy_q;
    logic        req_write_q, req_write_d;
    logic [7:0]  req_cmd_q, req_cmd_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [3:0]  req_len_q, req_len_d;

    logic [2:0]      idx_q;
    logic [6:0][7:0] shadow_q;
    logic [15:0]     clear_q, red_q, green_q, blue_q;
    logic            data_valid_q, sensor_ready_q, nack_err_q;

    logic launch, rsp_done, rsp_fail, beat, publish, ready_set, in_req;

    assign rsp_done = busy_q & rsp_valid & rsp_last;
    assign beat     = busy_q & rsp_valid & ~rsp_last;
    assign rsp_fail = rsp_done &
                      (rsp_err | ((state_q == S_READ) && (idx_q != 3'd7)));
    assign in_req   = state_q inside {S_PON, S_WR_ATIME, S_WR_CTRL,
                                      S_WR_EN, S_POLL, S_READ};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        launch    = in_req & ~req_valid_q & ~busy_q;
        publish   = 1'b0;
        ready_set = 1'b0;
        unique case (state_q)
            S_PON: begin
                if (rsp_done) begin
                    state_d = S_PON_WAIT;
                    cnt_d   = PON_LD;
                end
            end
            S_PON_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_ATIME;
                    launch  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_WR_ATIME: begin
                if (rsp_done) begin
                    state_d = S_WR_CTRL;
                    launch  = 1'b1;
                end
            end
            S_WR_CTRL: begin
                if (rsp_done) begin
                    state_d = S_WR_EN;
                    launch  = 1'b1;
                end
            end
            S_WR_EN: begin
                if (rsp_done) begin
                    state_d   = S_POLL;
                    launch    = 1'b1;
                    ready_set = 1'b1;
                end
            end
            S_POLL: begin
                if (rsp_done && rsp_data[0]) begin
                    state_d = S_READ;
                    launch  = 1'b1;
                end else if (rsp_done) begin
                    state_d = S_POLL_WAIT;
                    cnt_d   = GAP_LD;
                end
            end
            S_POLL_WAIT, S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_POLL;
                    launch  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_READ: begin
                if (rsp_done) begin
                    state_d = S_PUBLISH;
                    publish = 1'b1;
                end
            end
            S_PUBLISH: begin
                state_d = S_GAP;
                cnt_d   = GAP_LD;
            end
            S_ERR: begin
                if (cnt_q == '0) begin
                    state_d = S_PON;
                    launch  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = S_PON;
        endcase
        // Any NACK (or a truncated burst) overrides the normal successor.
        if (rsp_fail) begin
            state_d   = S_ERR;
            cnt_d     = ERR_LD;
            launch    = 1'b0;
            publish   = 1'b0;
            ready_set = 1'b0;
        end
    end

    always_comb begin
        req_write_d = 1'b0;
        req_cmd_d   = 8'h00;
        req_wdata_d = 8'h00;
        req_len_d   = 4'd0;
        case (state_d)
            S_PON: begin
                req_write_d = 1'b1;
                req_cmd_d   = 8'h80;
                req_wdata_d = 8'h01;
            end
            S_WR_ATIME: begin
                req_write_d = 1'b1;
                req_cmd_d   = 8'h81;
                req_wdata_d = ATIME_VAL;
            end
            S_WR_CTRL: begin
                req_write_d = 1'b1;
                req_cmd_d   = 8'h8F;
                req_wdata_d = {6'b0, GAIN_VAL};
            end
            S_WR_EN: begin
                req_write_d = 1'b1;
                req_cmd_d   = 8'h80;
                req_wdata_d = 8'h03;
            end
            S_POLL: begin
                req_cmd_d = 8'h93;
                req_len_d = 4'd1;
            end
            S_READ: begin
                req_cmd_d = 8'hB4;
                req_len_d = 4'd8;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_PON;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_write_q <= 1'b0;
            req_cmd_q   <= 8'h00;
            req_wdata_q <= 8'h00;
            req_len_q   <= 4'd0;
        end else begin
            if (launch) begin
                req_valid_q <= 1'b1;
                req_write_q <= req_write_d;
                req_cmd_q   <= req_cmd_d;
                req_wdata_q <= req_wdata_d;
                req_len_q   <= req_len_d;
            end else if (req_valid_q && req_ready) begin
                req_valid_q <= 1'b0;
                busy_q      <= 1'b1;
            end
            if (rsp_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= 3'd0;
            shadow_q <= '0;
        end else if (rsp_fail) begin
            idx_q    <= 3'd0;
            shadow_q <= '0;
        end else if (launch) begin
            idx_q <= 3'd0;
        end else if (beat && state_q == S_READ) begin
            if (idx_q != 3'd7) begin
                shadow_q[idx_q] <= rsp_data;
            end
            idx_q <= idx_q + 3'd1;
        end
    end

    // The final beat (BH) is taken straight from the bus so the channels
    // update on the same edge that sees rsp_last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_q        <= 16'h0;
            red_q          <= 16'h0;
            green_q        <= 16'h0;
            blue_q         <= 16'h0;
            data_valid_q   <= 1'b0;
            sensor_ready_q <= 1'b0;
            nack_err_q     <= 1'b0;
        end else begin
            data_valid_q <= publish;
            nack_err_q   <= rsp_fail;
            if (publish) begin
                clear_q <= {shadow_q[1], shadow_q[0]};
                red_q   <= {shadow_q[3], shadow_q[2]};
                green_q <= {shadow_q[5], shadow_q[4]};
                blue_q  <= {rsp_data, shadow_q[6]};
            end
            if (rsp_fail) begin
                sensor_ready_q <= 1'b0;
            end else if (ready_set) begin
                sensor_ready_q <= 1'b1;
            end
        end
    end

    assign req_valid    = req_valid_q;
    assign req_write    = req_write_q;
    assign req_cmd      = req_cmd_q;
    assign req_wdata    = req_wdata_q;
    assign req_len      = req_len_q;
    assign clear        = clear_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign data_valid   = data_valid_q;
    assign sensor_ready = sensor_ready_q;
    assign nack_err     = nack_err_q;

endmodule

// File: tb/tb_tcs34725_reader.sv
// Bench for tcs34725_reader: plays the I2C master and sensor, checks request
// order, wait timing and channel words against a simple sensor model.
module tb_tcs34725_reader;

    localparam int PON = 20;
    localparam int GAP = 6;
    localparam int ERR = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_cmd, req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [7:0]  rsp_data;
    logic [15:0] clear, red, green, blue;
    logic        data_valid, sensor_ready, nack_err;

    int vecs = 0;
    int miscmp = 0;
    int dv_cnt = 0;
    int nack_cnt = 0;
    int xfer_cnt = 0;

    logic [7:0]  rd_bytes [8];
    logic [15:0] exp_ch [4];

    tcs34725_reader #(
        .PON_WAIT_CYC   (PON),
        .POLL_GAP_CYC   (GAP),
        .ERR_BACKOFF_CYC(ERR),
        .ATIME_VAL      (8'hF6),
        .GAIN_VAL       (2'b01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_cmd     (req_cmd),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err),
        .clear       (clear),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .data_valid  (data_valid),
        .sensor_ready(sensor_ready),
        .nack_err    (nack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && data_valid) dv_cnt++;
        if (rst && nack_err) nack_cnt++;
        if (rst && req_valid && req_ready) xfer_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_channels(input string tag);
        check({tag, "_clear"}, clear, exp_ch[0]);
        check({tag, "_red"},   red,   exp_ch[1]);
        check({tag, "_green"}, green, exp_ch[2]);
        check({tag, "_blue"},  blue,  exp_ch[3]);
    endtask

    // Sensor model: each channel is its high byte times 256 plus its low byte.
    task automatic model_sample();
        for (int c = 0; c < 4; c++)
            exp_ch[c] = 16'(rd_bytes[2*c+1]) * 16'd256 + 16'(rd_bytes[2*c]);
    endtask

    task automatic wait_req(input string tag, input int start, output int idle);
        int n;
        idle = start;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_valid === 1'b1) break;
            idle++;
            n++;
            if (n > 2000) break;
        end
        check({tag, "_seen"}, {31'd0, req_valid}, 32'd1);
    endtask

    task automatic xfer(input int nbeats, input logic is_write, input logic err);
        @(posedge clk);
        #1;
        check("req_drop", {31'd0, req_valid}, 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = is_write ? 8'h00 : rd_bytes[i];
            rsp_last  = (i == nbeats - 1);
            rsp_err   = err && (i == nbeats - 1);
            @(posedge clk);
            #1;
        end
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 8'h00;
    endtask

    task automatic write_step(input string tag, input logic [7:0] cmd,
                              input logic [7:0] wd, input int exp_idle,
                              input int bp, input int start);
        int idle;
        req_ready = (bp == 0);
        wait_req(tag, start, idle);
        if (exp_idle >= 0) check({tag, "_idle"}, idle, exp_idle);
        check({tag, "_req"}, {req_write, req_len, req_cmd, req_wdata},
              {1'b1, 4'd0, cmd, wd});
        for (int k = 1; k < bp; k++) begin
            @(negedge clk);
            check({tag, "_hold"}, {req_valid, req_cmd, req_wdata},
                  {1'b1, cmd, wd});
        end
        req_ready = 1'b1;
        xfer(1, 1'b1, 1'b0);
    endtask

    task automatic read_step(input string tag, input logic [7:0] cmd,
                             input logic [3:0] len, input int nbeats,
                             input logic err, input int exp_idle);
        int idle;
        req_ready = 1'b1;
        wait_req(tag, 0, idle);
        if (exp_idle >= 0) check({tag, "_idle"}, idle, exp_idle);
        check({tag, "_req"}, {req_write, req_len, req_cmd, req_wdata},
              {1'b0, len, cmd, 8'h00});
        xfer(nbeats, 1'b0, err);
    endtask

    task automatic init(input string tag, input int pon_idle,
                        input int pon_start, input int bp);
        int x0;
        write_step({tag, "_pon"}, 8'h80, 8'h01, pon_idle, 0, pon_start);
        x0 = xfer_cnt;
        write_step({tag, "_atime"}, 8'h81, 8'hF6, PON, bp, 0);
        check({tag, "_one_xfer"}, xfer_cnt, x0 + 1);
        check({tag, "_not_ready"}, {31'd0, sensor_ready}, 32'd0);
        write_step({tag, "_ctrl"}, 8'h8F, 8'h01, -1, 0, 0);
        write_step({tag, "_en"}, 8'h80, 8'h03, -1, 0, 0);
        check({tag, "_ready"}, {31'd0, sensor_ready}, 32'd1);
    endtask

    task automatic poll(input string tag, input int misses, input bit fixed);
        for (int m = 0; m < misses; m++) begin
            rd_bytes[0] = fixed ? 8'h00 : (8'($urandom) & 8'hFE);
            read_step({tag, "_miss"}, 8'h93, 4'd1, 1, 1'b0, (m == 0) ? -1 : GAP);
        end
        rd_bytes[0] = fixed ? 8'h11 : (8'($urandom) | 8'h01);
        read_step({tag, "_hit"}, 8'h93, 4'd1, 1, 1'b0, (misses == 0) ? -1 : GAP);
    endtask

    task automatic good_read(input string tag);
        int d0;
        d0 = dv_cnt;
        read_step({tag, "_rd"}, 8'hB4, 4'd8, 8, 1'b0, -1);
        model_sample();
        @(negedge clk);
        check({tag, "_dv_hi"}, {31'd0, data_valid}, 32'd1);
        check_channels(tag);
        @(negedge clk);
        check({tag, "_dv_lo"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_dv_once"}, dv_cnt, d0 + 1);
    endtask

    task automatic nack_read(input string tag, input int nbeats, input logic err);
        int d0, n0;
        d0 = dv_cnt;
        n0 = nack_cnt;
        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
        read_step({tag, "_rd"}, 8'hB4, 4'd8, nbeats, err, -1);
        @(negedge clk);
        check({tag, "_nack"}, {nack_err, data_valid, sensor_ready}, {1'b1, 1'b0, 1'b0});
        check_channels(tag);
        init({tag, "_re"}, ERR, 1, 0);
        check({tag, "_nack_once"}, nack_cnt, n0 + 1);
        check({tag, "_no_dv"}, dv_cnt, d0);
    endtask

    initial begin
        int d0, n0, x0, idle;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 8'h00;
        for (int c = 0; c < 4; c++) exp_ch[c] = 16'h0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {req_valid, req_write, req_cmd, req_wdata, req_len},
              21'd0);
        check("rst_flags", {data_valid, sensor_ready, nack_err}, 3'd0);
        check_channels("rst");
        rst = 1'b1;

        init("init", 0, 0, 7);

        poll("p0", 2, 1'b1);
        rd_bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        good_read("r0");

        for (int it = 0; it < 3; it++) begin
            poll("pr", $urandom_range(0, 2), 1'b0);
            for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
            good_read("rr");
        end

        poll("pn", $urandom_range(0, 1), 1'b0);
        nack_read("nack8", 8, 1'b1);

        poll("ps", 0, 1'b0);
        nack_read("short5", 5, 1'b0);

        poll("pz", 0, 1'b0);
        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
        read_step("rz_rd", 8'hB4, 4'd8, 0, 1'b0, -1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = rd_bytes[i];
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) exp_ch[c] = 16'h0;
        check("rz_req", {req_valid, req_write, req_cmd, req_wdata, req_len},
              21'd0);
        check("rz_flags", {data_valid, sensor_ready, nack_err}, 3'd0);
        check_channels("rz");
        d0 = dv_cnt;
        n0 = nack_cnt;
        req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 3; i < 8; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = rd_bytes[i];
            rsp_last  = (i == 7);
            @(posedge clk);
            #1;
        end
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_data  = 8'h00;
        x0 = xfer_cnt;
        wait_req("rz_pon", 0, idle);
        check("rz_pon_req", {req_write, req_len, req_cmd, req_wdata},
              {1'b1, 4'd0, 8'h80, 8'h01});
        check("rz_ignored", {dv_cnt - d0, nack_cnt - n0, xfer_cnt - x0}, 96'd0);
        check_channels("rz_after");
        req_ready = 1'b1;
        xfer(1, 1'b1, 1'b0);
        check("rz_xfer", xfer_cnt, x0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
